// File: rtl/riscv_pkg.sv
// RISC-V constants and load/store lane helpers shared by the MEM-stage blocks.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    function automatic logic [3:0] lane_mask(input acc_size_e sz, input logic [1:0] off);
        logic [3:0] mask;
        mask = 4'b0000;
        case (sz)
            SZ_BYTE: mask = 4'b0001 << off;
            SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Store data is right-justified, so copying it into every lane lets the
    // byte enables alone pick which copy reaches the array.
    function automatic logic [XLEN-1:0] lane_replicate(input acc_size_e sz, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] rep;
        rep = data;
        case (sz)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh  = word >> {off, 3'b000};
        res = sh;
        case (f3)
            F3_LB:   res = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency, in-order response shift register carrying {valid, err, rdata}.
module mem_resp_pipe
    import riscv_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int WIDTH   = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_err,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_err,
    output logic [WIDTH-1:0] o_data
);

    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_err;
    logic [WIDTH-1:0]   r_data [LATENCY];

    // Reset drops every in-flight response so none is emitted afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_err;
            r_data[0]  <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_err   = r_err[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable RISC-V data memory with load/store alignment, fault detection
// and a fixed-latency in-order response pipeline.
module data_mem_lsu
    import riscv_pkg::*;
#(
    parameter int    DEPTH_WORDS  = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    logic            r_ready;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_load_size_ok;
    logic            w_store_size_ok;
    logic            w_size_ok;
    logic            w_align_ok;
    logic            w_range_ok;
    logic            w_err;
    acc_size_e       w_sz;
    logic [1:0]      w_off;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_pipe_data;

    // Ready drops with reset and comes back on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign req_ready = r_ready;
    assign w_accept  = req_valid && r_ready;
    assign w_off     = req_addr[1:0];
    assign w_idx     = req_addr[AW+1:2];

    assign w_load_size_ok  = req_size inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign w_store_size_ok = req_size inside {F3_SB, F3_SH, F3_SW};
    assign w_size_ok       = req_we ? w_store_size_ok : w_load_size_ok;

    // The low two funct3 bits encode the access width for every legal opcode.
    always_comb begin
        w_sz       = SZ_WORD;
        w_align_ok = 1'b0;
        case (req_size[1:0])
            2'b00: begin
                w_sz       = SZ_BYTE;
                w_align_ok = 1'b1;
            end
            2'b01: begin
                w_sz       = SZ_HALF;
                w_align_ok = (w_off[0] == 1'b0);
            end
            default: begin
                w_sz       = SZ_WORD;
                w_align_ok = (w_off == 2'b00);
            end
        endcase
    end

    assign w_range_ok  = {1'b0, req_addr} < BYTE_LIMIT;
    assign w_err       = !(w_size_ok && w_align_ok && w_range_ok);
    assign w_be        = lane_mask(w_sz, w_off);
    assign w_wdata_rep = lane_replicate(w_sz, req_wdata);

    // The array has no reset so committed stores survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign w_word      = r_mem[w_idx];
    assign w_pipe_data = (w_accept && !req_we && !w_err) ? load_extract(w_word, req_size, w_off)
                                                         : '0;

    mem_resp_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (XLEN)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_err   (w_accept && w_err),
        .i_data  (w_pipe_data),
        .o_valid (rsp_valid),
        .o_err   (rsp_err),
        .o_data  (rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: three instances (latency 1/3/4, one with a
// 64-word array) share stimulus; responses are checked against a due-cycle table.
module tb_data_mem_lsu;
    import riscv_pkg::*;

    localparam int LAT [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqWe;
    logic [2:0]  reqSize;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    logic [2:0]  reqReady;
    logic [2:0]  rspValid;
    logic [2:0]  rspErr;
    logic [31:0] rspData [3];

    logic        expV [3][8];
    logic [31:0] expD [3][8];
    logic        expE [3][8];

    int checks   = 0;
    int failures = 0;
    int edgeCnt  = 0;
    bit monEn    = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    data_mem_lsu #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) dutL1 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady[0]),
        .req_we(reqWe), .req_size(reqSize), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid[0]), .rsp_rdata(rspData[0]), .rsp_err(rspErr[0]));

    data_mem_lsu #(.DEPTH_WORDS(64), .READ_LATENCY(3)) dutL3 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady[1]),
        .req_we(reqWe), .req_size(reqSize), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid[1]), .rsp_rdata(rspData[1]), .rsp_err(rspErr[1]));

    data_mem_lsu #(.DEPTH_WORDS(1024), .READ_LATENCY(4)) dutL4 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady[2]),
        .req_we(reqWe), .req_size(reqSize), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid[2]), .rsp_rdata(rspData[2]), .rsp_err(rspErr[2]));

    task automatic checkOutput(input string tag, input int dut, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s dut%0d edge=%0d observed=0x%08h expected=0x%08h",
                   tag, dut, edgeCnt, obs, exp);
        end
    endtask

    task automatic clearExpected();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 8; s++) begin
                expV[d][s] = 1'b0;
                expD[d][s] = '0;
                expE[d][s] = 1'b0;
            end
        end
    endtask

    // Index 1 is the 64-word instance, so it takes the "small" expectations.
    task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] expBig, input logic errBig,
                                 input logic [31:0] expSmall, input logic errSmall);
        int slot;
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = we;
        reqSize  = size;
        reqAddr  = addr;
        reqWdata = wdata;
        for (int d = 0; d < 3; d++) begin
            slot = (edgeCnt + LAT[d]) % 8;
            expV[d][slot] = 1'b1;
            expD[d][slot] = (d == 1) ? expSmall : expBig;
            expE[d][slot] = (d == 1) ? errSmall : errBig;
        end
    endtask

    task automatic applyAll(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expData, input logic expErr);
        applyStimulus(we, size, addr, wdata, expData, expErr, expData, expErr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reqValid = 1'b0;
        end
    endtask

    task automatic checkQuiet(input string tag, input logic [31:0] expReady);
        for (int d = 0; d < 3; d++) begin
            checkOutput({tag, "_ready"}, d, {31'b0, reqReady[d]}, expReady);
            checkOutput({tag, "_valid"}, d, {31'b0, rspValid[d]}, 32'd0);
            checkOutput({tag, "_rdata"}, d, rspData[d], 32'd0);
            checkOutput({tag, "_err"}, d, {31'b0, rspErr[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        int slot;
        if (monEn && rst) begin
            slot = edgeCnt % 8;
            for (int d = 0; d < 3; d++) begin
                checkOutput("req_ready", d, {31'b0, reqReady[d]}, 32'd1);
                checkOutput("rsp_valid", d, {31'b0, rspValid[d]}, {31'b0, expV[d][slot]});
                if (expV[d][slot]) begin
                    checkOutput("rsp_rdata", d, rspData[d], expD[d][slot]);
                    checkOutput("rsp_err", d, {31'b0, rspErr[d]}, {31'b0, expE[d][slot]});
                end
                expV[d][slot] = 1'b0;
            end
        end
    end

    initial begin
        rst      = 1'b0;
        reqValid = 1'b0;
        reqWe    = 1'b0;
        reqSize  = F3_LW;
        reqAddr  = '0;
        reqWdata = '0;
        clearExpected();

        repeat (2) begin
            @(negedge clk);
            checkQuiet("reset", 32'd0);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) checkOutput("ready_before_edge", d, {31'b0, reqReady[d]}, 32'd0);
        @(negedge clk);
        checkQuiet("release", 32'd1);
        monEn = 1'b1;

        applyAll(1'b1, F3_SW,  32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
        applyAll(1'b0, F3_LB,  32'hB, 32'h0, 32'hFFFFFFDE, 1'b0);
        applyAll(1'b0, F3_LBU, 32'hB, 32'h0, 32'h000000DE, 1'b0);
        applyAll(1'b0, F3_LH,  32'hA, 32'h0, 32'hFFFFDEAD, 1'b0);
        applyAll(1'b0, F3_LHU, 32'h8, 32'h0, 32'h0000BEEF, 1'b0);
        applyAll(1'b0, F3_LW,  32'h8, 32'h0, 32'hDEADBEEF, 1'b0);
        applyAll(1'b0, F3_LB,  32'h8, 32'h0, 32'hFFFFFFEF, 1'b0);
        applyAll(1'b0, F3_LBU, 32'h9, 32'h0, 32'h000000BE, 1'b0);
        applyAll(1'b1, F3_SB,  32'h9, 32'hAABBCC12, 32'h0, 1'b0);
        applyAll(1'b0, F3_LW,  32'h8, 32'h0, 32'hDEAD12EF, 1'b0);
        applyAll(1'b0, F3_LH,  32'h8, 32'h0, 32'h000012EF, 1'b0);
        idle(5);

        applyAll(1'b1, F3_SW,  32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        applyAll(1'b1, F3_SW,  32'h4, 32'h11223344, 32'h0, 1'b0);
        applyAll(1'b1, F3_SH,  32'h6, 32'hFFFF5678, 32'h0, 1'b0);
        applyAll(1'b0, F3_LHU, 32'h6, 32'h0, 32'h00005678, 1'b0);
        applyAll(1'b0, F3_LH,  32'h4, 32'h0, 32'h00003344, 1'b0);
        applyAll(1'b0, F3_LW,  32'h6, 32'h0, 32'h0, 1'b1);
        applyAll(1'b1, F3_SH,  32'h3, 32'h0000BEEF, 32'h0, 1'b1);
        applyAll(1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1);
        applyAll(1'b1, F3_LBU, 32'h4, 32'h0, 32'h0, 1'b1);
        applyAll(1'b1, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1);
        applyAll(1'b0, F3_LW,  32'h1000, 32'h0, 32'h0, 1'b1);
        applyAll(1'b0, F3_LW,  32'h80000004, 32'h0, 32'h0, 1'b1);
        applyAll(1'b0, F3_LW,  32'h4, 32'h0, 32'h56783344, 1'b0);
        applyAll(1'b0, F3_LW,  32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        idle(5);

        applyStimulus(1'b1, F3_SW, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, F3_LW, 32'h100, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, F3_SW, 32'hFFC, 32'h76543210, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, F3_LW, 32'hFFC, 32'h0, 32'h76543210, 1'b0, 32'h0, 1'b1);
        applyAll(1'b1, F3_SW,  32'hFC, 32'h0BADCAFE, 32'h0, 1'b0);
        applyAll(1'b0, F3_LW,  32'hFC, 32'h0, 32'h0BADCAFE, 1'b0);
        applyAll(1'b0, F3_LHU, 32'hFE, 32'h0, 32'h00000BAD, 1'b0);
        applyAll(1'b0, F3_LB,  32'hFC, 32'h0, 32'hFFFFFFFE, 1'b0);
        idle(5);

        applyAll(1'b1, F3_SW, 32'h10, 32'h13572468, 32'h0, 1'b0);
        applyAll(1'b0, F3_LW, 32'h10, 32'h0, 32'h13572468, 1'b0);
        applyAll(1'b0, F3_LW, 32'h8, 32'h0, 32'hDEAD12EF, 1'b0);
        @(posedge clk);
        #1;
        monEn = 1'b0;
        rst   = 1'b0;
        clearExpected();
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqSize  = F3_LW;
        reqAddr  = 32'h0;
        checkQuiet("midreset", 32'd0);
        @(negedge clk);
        checkQuiet("midreset_hold", 32'd0);
        reqWe    = 1'b1;
        reqSize  = F3_SW;
        reqAddr  = 32'h10;
        reqWdata = 32'hFFFFFFFF;
        rst      = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) checkOutput("ready_after_release", d, {31'b0, reqReady[d]}, 32'd0);
        @(negedge clk);
        reqValid = 1'b0;
        checkQuiet("post_reset", 32'd1);
        monEn = 1'b1;
        applyAll(1'b0, F3_LW, 32'h10, 32'h0, 32'h13572468, 1'b0);
        applyAll(1'b0, F3_LW, 32'h8, 32'h0, 32'hDEAD12EF, 1'b0);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
